// File: rtl/lrx_pkg.sv
// Shared definitions for the pulse measurement block.
//   CNT_W_DEF : default width of the high-time / period counters
//   state_e   : measurement FSM states
package lrx_pkg;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used as the time base of pulse_meas.
//   clk_in, rst_in : clock, synchronous active-high reset
//   clr_in         : clear to 0 (highest priority)
//   load1_in       : load 1 (start of a new period)
//   inc_in         : increment by 1, holding at all-ones
//   cnt_out        : current count
//   sat_out        : count is all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         clr_in,
  input  logic         load1_in,
  input  logic         inc_in,
  output logic [W-1:0] cnt_out,
  output logic         sat_out
);
  logic [W-1:0] cnt_q, cnt_d;

  assign sat_out = &cnt_q;
  assign cnt_out = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_in)                  cnt_d = '0;
    else if (load1_in)           cnt_d = {{(W-1){1'b0}}, 1'b1};
    else if (inc_in && !sat_out) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pulse_meas.sv
// Measures high time and rise-to-rise period of a signal presented as
// single-cycle rise/fall pulses.
//   clk_in, rst_in   : clock, synchronous active-high reset
//   en_in            : measurement enable (low forces IDLE)
//   rise_in, fall_in : edge pulses; both high together is no event
//   high_cnt_out     : last captured high time (cycles)
//   period_cnt_out   : last captured period (cycles)
//   valid_out        : one-cycle strobe with each new result pair
//   timeout_out      : one-cycle strobe when the counter saturated
//   busy_out         : FSM not in IDLE
module pulse_meas
  import lrx_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             rise_in,
  input  logic             fall_in,
  output logic [CNT_W-1:0] high_cnt_out,
  output logic [CNT_W-1:0] period_cnt_out,
  output logic             valid_out,
  output logic             timeout_out,
  output logic             busy_out
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_sat, cnt_clr, cnt_load1, cnt_inc;
  logic [CNT_W-1:0] high_hold_q, high_hold_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             valid_q, valid_d, timeout_q, timeout_d;
  logic             ev_rise, ev_fall;

  // Coincident rise and fall cancel out.
  assign ev_rise = rise_in & ~fall_in;
  assign ev_fall = fall_in & ~rise_in;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr_in   (cnt_clr),
    .load1_in (cnt_load1),
    .inc_in   (cnt_inc),
    .cnt_out  (cnt),
    .sat_out  (cnt_sat)
  );

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: accepted edges win over saturation timeout.
  always_comb begin
    state_d = state_q;
    if (!en_in) state_d = ST_IDLE;
    else begin
      unique case (state_q)
        ST_IDLE: if (ev_rise) state_d = ST_HIGH;
        ST_HIGH: if (ev_fall) state_d = ST_LOW;
                 else if (cnt_sat) state_d = ST_IDLE;
        ST_LOW:  if (ev_rise) state_d = ST_HIGH;
                 else if (cnt_sat) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Counter control and output register inputs
  always_comb begin
    cnt_clr      = 1'b0;
    cnt_load1    = 1'b0;
    cnt_inc      = (state_q != ST_IDLE);
    high_hold_d  = high_hold_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = 1'b0;
    timeout_d    = 1'b0;
    if (!en_in) begin
      cnt_clr     = 1'b1;
      high_hold_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (ev_rise) cnt_load1 = 1'b1;
        ST_HIGH: begin
          if (ev_fall) high_hold_d = cnt;
          else if (cnt_sat) begin
            cnt_clr   = 1'b1;
            timeout_d = 1'b1;
          end
        end
        ST_LOW: begin
          // The closing rise also opens the next period.
          if (ev_rise) begin
            cnt_load1    = 1'b1;
            high_cnt_d   = high_hold_q;
            period_cnt_d = cnt;
            valid_d      = 1'b1;
          end else if (cnt_sat) begin
            cnt_clr   = 1'b1;
            timeout_d = 1'b1;
          end
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      high_hold_q  <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      high_hold_q  <= high_hold_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign high_cnt_out   = high_cnt_q;
  assign period_cnt_out = period_cnt_q;
  assign valid_out      = valid_q;
  assign timeout_out    = timeout_q;
  assign busy_out       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_pulse_meas.sv
`timescale 1ns/1ps
module tb_pulse_meas;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, rise, fall;
  logic [15:0] hi16, pe16;
  logic        v16, t16, b16;
  logic [3:0]  hi4, pe4;
  logic        v4, t4, b4;

  pulse_meas #(.CNT_W(16)) dut16 (
    .clk_in(clk), .rst_in(rst), .en_in(en), .rise_in(rise), .fall_in(fall),
    .high_cnt_out(hi16), .period_cnt_out(pe16), .valid_out(v16),
    .timeout_out(t16), .busy_out(b16));

  pulse_meas #(.CNT_W(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .en_in(en), .rise_in(rise), .fall_in(fall),
    .high_cnt_out(hi4), .period_cnt_out(pe4), .valid_out(v4),
    .timeout_out(t4), .busy_out(b4));

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  // Reference model, one slot per DUT (0: 16-bit, 1: 4-bit).
  // Phase 0 idle, 1 signal high, 2 signal low. Times are kept as absolute
  // cycle numbers; the count is the distance from the opening rise.
  int     m_ph[2];
  longint m_tr[2], m_hl[2], m_hi[2], m_pe[2];
  bit     m_v[2], m_t[2];
  longint maxv[2];

  typedef struct {
    int fall_at;
    int rise_at;
    int exp_high;
    int exp_period;
  } meas_t;
  meas_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model(input int i);
    longint e;
    bit er, ef;
    e  = cyc - m_tr[i];
    er = rise & !fall;
    ef = fall & !rise;
    m_v[i] = 0;
    m_t[i] = 0;
    if (rst) begin
      m_ph[i] = 0; m_hl[i] = 0; m_hi[i] = 0; m_pe[i] = 0;
    end else if (!en) begin
      m_ph[i] = 0; m_hl[i] = 0;
    end else begin
      case (m_ph[i])
        0: if (er) begin m_ph[i] = 1; m_tr[i] = cyc; end
        1: if (ef) begin
             m_hl[i] = (e < maxv[i]) ? e : maxv[i];
             m_ph[i] = 2;
           end else if (e >= maxv[i]) begin
             m_t[i] = 1; m_ph[i] = 0;
           end
        default: if (er) begin
             m_hi[i] = m_hl[i];
             m_pe[i] = (e < maxv[i]) ? e : maxv[i];
             m_v[i]  = 1;
             m_tr[i] = cyc;
             m_ph[i] = 1;
           end else if (e >= maxv[i]) begin
             m_t[i] = 1; m_ph[i] = 0;
           end
      endcase
    end
  endtask

  task automatic step(input bit r, input bit en_i, input bit ri, input bit fa);
    rst = r; en = en_i; rise = ri; fall = fa;
    @(posedge clk);
    model(0);
    model(1);
    cyc++;
    #1;
    chk("hi16",  hi16, m_hi[0]);
    chk("pe16",  pe16, m_pe[0]);
    chk("v16",   v16,  m_v[0]);
    chk("t16",   t16,  m_t[0]);
    chk("busy16", b16, m_ph[0] != 0);
    chk("hi4",   hi4,  m_hi[1]);
    chk("pe4",   pe4,  m_pe[1]);
    chk("v4",    v4,   m_v[1]);
    chk("t4",    t4,   m_t[1]);
    chk("busy4", b4,   m_ph[1] != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nv, first_to;
    maxv[0] = 65535; maxv[1] = 15;
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_tr[i] = 0; m_hl[i] = 0; m_hi[i] = 0; m_pe[i] = 0;
      m_v[i] = 0; m_t[i] = 0;
    end
    tbl[0] = '{5, 12, 5, 12};
    tbl[1] = '{1, 2, 1, 2};
    tbl[2] = '{3, 8, 3, 8};
    tbl[3] = '{14, 15, 14, 15};   // closing rise lands on the saturated count
    tbl[4] = '{7, 9, 7, 9};
    rst = 1; en = 0; rise = 0; fall = 0;
    #2;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    chk("rst_hi16", hi16, 0); chk("rst_pe16", pe16, 0);
    chk("rst_v16", v16, 0);   chk("rst_busy16", b16, 0);
    chk("rst_t4", t4, 0);     chk("rst_busy4", b4, 0);

    // Table of single measurements
    foreach (tbl[n]) begin
      step(0, 1, 1, 0);
      for (int k = 1; k <= tbl[n].rise_at; k++) begin
        step(0, 1, k == tbl[n].rise_at, k == tbl[n].fall_at);
        if (k < tbl[n].rise_at) chk("tbl_early_v16", v16, 0);
      end
      chk("tbl_v16", v16, 1);  chk("tbl_hi16", hi16, tbl[n].exp_high);
      chk("tbl_pe16", pe16, tbl[n].exp_period);
      chk("tbl_v4", v4, 1);    chk("tbl_hi4", hi4, tbl[n].exp_high);
      chk("tbl_pe4", pe4, tbl[n].exp_period);
      step(0, 0, 0, 0);
      chk("tbl_idle16", b16, 0);
    end

    // Back-to-back periods
    nv = 0;
    for (int k = 0; k <= 16; k++) begin
      step(0, 1, (k % 8) == 0, k == 3 || k == 11);
      nv += int'(v16);
    end
    chk("b2b_nvalid", nv, 2);
    chk("b2b_hi16", hi16, 3); chk("b2b_pe16", pe16, 8);
    chk("b2b_busy16", b16, 1);
    step(0, 0, 0, 0);

    // Disable mid-measurement: no strobe, results held
    for (int k = 0; k <= 6; k++) step(0, k != 6, k == 0, k == 4);
    chk("dis_busy16", b16, 0); chk("dis_v16", v16, 0);
    chk("dis_hi16", hi16, 3);  chk("dis_pe16", pe16, 8);
    chk("dis_hi4", hi4, 3);    chk("dis_pe4", pe4, 8);

    // Coincident rise+fall ignored inside HIGH
    for (int k = 0; k <= 9; k++) step(0, 1, k == 0 || k == 3 || k == 9, k == 3 || k == 5);
    chk("ill_v16", v16, 1); chk("ill_hi16", hi16, 5); chk("ill_pe16", pe16, 9);
    step(0, 0, 0, 0);

    // Saturation timeout on the 4-bit instance
    first_to = -1;
    step(0, 1, 1, 0);
    for (int k = 1; k <= 18; k++) begin
      step(0, 1, 0, 0);
      if (t4 && first_to < 0) first_to = k;
      chk("to_nov4", v4, 0);
    end
    chk("to_cycle4", first_to, 15);
    chk("to_busy4", b4, 0);
    chk("to_busy16", b16, 1); chk("to_t16", t16, 0);
    chk("to_hi4", hi4, 5);    chk("to_pe4", pe4, 9);
    step(0, 0, 0, 0);

    // Reset during LOW, then a clean period
    for (int k = 0; k <= 3; k++) step(0, 1, k == 0, k == 2);
    step(1, 1, 1, 0);
    chk("rl_hi16", hi16, 0); chk("rl_pe16", pe16, 0); chk("rl_v16", v16, 0);
    chk("rl_t16", t16, 0);   chk("rl_busy16", b16, 0);
    for (int k = 0; k <= 10; k++) step(0, 1, k == 0 || k == 10, k == 4);
    chk("rl_v16b", v16, 1); chk("rl_hi16b", hi16, 4); chk("rl_pe16b", pe16, 10);
    step(0, 0, 0, 0);

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      int rp;
      rp = (k / 500) % 2 == 0 ? 5 : 14;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) != 0,
           $urandom_range(0, rp) == 0, $urandom_range(0, rp) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_meas.md
PULSE_MEAS -- requirements
Module: pulse_meas

Interface
REQ-001 Parameter: CNT_W, 16, width of the high-time and period counters and result outputs.
REQ-002 clk_in  input  1  single block clock; all logic on its rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 en_in  input  1  measurement enable, level-sensitive.
REQ-005 rise_in  input  1  single-cycle rising-edge pulse of the measured signal.
REQ-006 fall_in  input  1  single-cycle falling-edge pulse of the measured signal.
REQ-007 high_cnt_out  output  CNT_W  last captured high time, in clk_in cycles.
REQ-008 period_cnt_out  output  CNT_W  last captured period (rise to rise), in clk_in cycles.
REQ-009 valid_out  output  1  one-cycle strobe; a new high_cnt_out/period_cnt_out pair is present.
REQ-010 timeout_out  output  1  one-cycle strobe; counter saturated and the measurement was aborted.
REQ-011 busy_out  output  1  high while state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, HIGH and LOW.
REQ-013 IDLE: on rise_in=1 and fall_in=0 with en_in=1, go to HIGH and load cnt=1; otherwise stay (fall_in ignored).
REQ-014 The cnt register SHALL hold k during the k-th cycle after the accepted rise pulse, incrementing by 1 per cycle.
REQ-015 HIGH: on fall_in=1, latch high_hold=cnt, go to LOW, and keep counting; rise_in alone is ignored.
REQ-016 LOW: on rise_in=1, load high_cnt_out=high_hold and period_cnt_out=cnt, assert valid_out on the next cycle, reload cnt=1 and go to HIGH; fall_in alone is ignored.
REQ-017 Latency: valid_out SHALL be high exactly in the cycle after the closing rise pulse, for one cycle.
REQ-018 Back-to-back measurements SHALL need no idle gap: the closing rise of period N is the opening rise of period N+1.
REQ-019 Simultaneous rise_in=1 and fall_in=1 SHALL be treated as no event in every state.
REQ-020 Saturation: in HIGH or LOW, if cnt=2^CNT_W-1 and no accepted edge occurs in that cycle, pulse timeout_out in the next cycle, go to IDLE and clear cnt. Result outputs are unchanged.
REQ-021 An accepted edge in the saturation cycle SHALL take priority over timeout.
REQ-022 en_in=0 in any state SHALL force IDLE and clear cnt and high_hold on the next edge. No valid_out or timeout_out is produced, and results are held.
REQ-023 high_cnt_out and period_cnt_out SHALL change only with valid_out; arithmetic is unsigned, with no wrap-around.

Reset
REQ-024 On rst_in=1 at a clock edge: state=IDLE; cnt, high_hold, high_cnt_out and period_cnt_out are 0; valid_out, timeout_out and busy_out are 0.
REQ-025 Reset mid-measurement SHALL discard the partial measurement, with no strobe.
REQ-026 rst_in SHALL take priority over en_in and over edge inputs.

Structure
REQ-027 The state encoding constants and the CNT_W default SHALL live in the shared package lrx_pkg.
REQ-028 The counter SHALL be one sub-module, sat_counter (synchronous load-1, increment, clear, saturation flag); the FSM and output registers stay in pulse_meas.

Verification
REQ-029 Basic: rise at t0, fall at t0+5, rise at t0+12 -> valid_out at t0+13 with high=5, period=12.
REQ-030 Back-to-back: rises at t0, t0+8, t0+16, falls at t0+3, t0+11 -> two valid strobes (high=3, period=8), no gap.
REQ-031 Timeout: CNT_W=4, rise at t0, no further edges -> timeout_out at t0+16, busy_out=0 after, no valid_out.
REQ-032 Disable: rise at t0, fall at t0+4, en_in=0 at t0+6 -> IDLE, no strobe, prior results held.
REQ-033 Illegal: rise and fall together at t0+3 inside HIGH -> ignored; a later fall at t0+5 gives high=5.
REQ-034 Reset: rst_in during LOW -> all outputs 0 next cycle, and the next full period measures correctly.
